// File: rtl/hmlf_pkg.sv
// Shared constants and types for the pipelined minimum-with-index tree.
package hmlf_pkg;
   localparam int HMLF_W    = 6;
   localparam int HMLF_N    = 8;
   localparam int HMLF_IDXW = 3;

   typedef logic signed [HMLF_W-1:0] hmlf_sample_t;

   typedef struct packed {
      hmlf_sample_t          val;
      logic [HMLF_IDXW-1:0]  idx;
   } hmlf_pair_t;
endpackage

// File: rtl/hmlf_min2_idx.sv
// One combinational tree node: picks the smaller signed value of two {value, index} pairs.
// Ties go to operand a (the lower-index child); the select bit lands at index bit LVL.
module hmlf_min2_idx
   import hmlf_pkg::*;
#(
   parameter int W   = HMLF_W,
   parameter int IW  = HMLF_IDXW,
   parameter int LVL = 0
) (
   input  logic signed [W-1:0]  a_val,
   input  logic        [IW-1:0] a_idx,
   input  logic signed [W-1:0]  b_val,
   input  logic        [IW-1:0] b_idx,
   output logic signed [W-1:0]  win_val,
   output logic        [IW-1:0] win_idx
);

   logic sel;

   assign sel = (b_val < a_val);

   always_comb begin
      win_val      = sel ? b_val : a_val;
      win_idx      = sel ? b_idx : a_idx;
      win_idx[LVL] = sel;
   end

endmodule

// File: rtl/hmlf_min8_pipe.sv
// Pipelined N-input signed minimum finder: log2(N) tree levels, one register stage per level,
// single global enable with valid/ready handshake and a synchronous flush of the valid chain.
module hmlf_min8_pipe
   import hmlf_pkg::*;
#(
   parameter int W = HMLF_W,
   parameter int N = HMLF_N
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [N*W-1:0]         in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic signed [W-1:0]    out_min,
   output logic [$clog2(N)-1:0]   out_idx,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int L     = $clog2(N);
   localparam int IW    = L;
   localparam int NODES = N - 1;

   // Nodes are numbered level by level: level l starts at N - (N >> l); the root is NODES-1.
   logic signed [W-1:0]  nxt_val [NODES];
   logic        [IW-1:0] nxt_idx [NODES];
   logic signed [W-1:0]  q_val   [NODES];
   logic        [IW-1:0] q_idx   [NODES];
   logic        [L-1:0]  vld;
   logic                 en;

   assign en       = !out_valid || out_ready;
   assign in_ready = en && !flush;

   for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar j = 0; j < (N >> (l + 1)); j++) begin : g_node
         localparam int NODE = N - (N >> l) + j;

         logic signed [W-1:0]  a_val;
         logic signed [W-1:0]  b_val;
         logic        [IW-1:0] a_idx;
         logic        [IW-1:0] b_idx;

         if (l == 0) begin : g_leaf
            assign a_val = in_data[(2*j)*W +: W];
            assign b_val = in_data[(2*j+1)*W +: W];
            assign a_idx = '0;
            assign b_idx = '0;
         end else begin : g_inner
            localparam int CBASE = N - (N >> (l - 1));
            assign a_val = q_val[CBASE + 2*j];
            assign b_val = q_val[CBASE + 2*j + 1];
            assign a_idx = q_idx[CBASE + 2*j];
            assign b_idx = q_idx[CBASE + 2*j + 1];
         end

         hmlf_min2_idx #(
            .W   (W),
            .IW  (IW),
            .LVL (l)
         ) u_node (
            .a_val   (a_val),
            .a_idx   (a_idx),
            .b_val   (b_val),
            .b_idx   (b_idx),
            .win_val (nxt_val[NODE]),
            .win_idx (nxt_idx[NODE])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NODES; i++) begin
            q_val[i] <= '0;
            q_idx[i] <= '0;
         end
         vld <= '0;
      end else begin
         if (en) begin
            for (int i = 0; i < NODES; i++) begin
               q_val[i] <= nxt_val[i];
               q_idx[i] <= nxt_idx[i];
            end
         end
         // Data may shift during a flush; only the valid chain has to be cleared.
         if (flush) begin
            vld <= '0;
         end else if (en) begin
            vld[0] <= in_valid;
            for (int k = 1; k < L; k++) begin
               vld[k] <= vld[k-1];
            end
         end
      end
   end

   assign out_min   = q_val[NODES-1];
   assign out_idx   = q_idx[NODES-1];
   assign out_valid = vld[L-1];

endmodule

// File: doc/hmlf_min8_pipe.md
HMLF_MIN8_PIPE -- requirements
Module: hmlf_min8_pipe

Interface
REQ-001 SHALL have parameter W, default 6, meaning signed sample width in bits.
REQ-002 SHALL have parameter N, default 8, meaning number of candidates; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline clear.
REQ-006 SHALL have port in_data  input  N*W  packed signed candidates; candidate k occupies bits [k*W+W-1 : k*W].
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_min  output  W  signed minimum of the accepted vector.
REQ-010 SHALL have port out_idx  output  log2(N)  index of the winning candidate.
REQ-011 SHALL have port out_valid  output  1  out_min and out_idx are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-013 SHALL compute the minimum over N candidates using a binary tree of log2(N) levels, with one register stage per level.
REQ-014 SHALL give a latency of exactly log2(N) cycles (3 cycles at N=8) from accept (in_valid and in_ready both 1) to out_valid, when not stalled.
REQ-015 SHALL compare candidates as two's-complement signed values; no widening and no saturation, with W-bit values passing through unchanged.
REQ-016 SHALL break ties at every node in favour of the lower-index operand, so equal values resolve to the lowest index overall.
REQ-017 SHALL form each node's index by concatenating the winner-select bit with the winning child's index, so the final out_idx equals the original candidate position.
REQ-018 SHALL drive in_ready = !out_valid || out_ready as a single global pipeline enable.
REQ-019 SHALL hold all stages (data, index and valid) unchanged while enable is 0, so no result is lost or duplicated.
REQ-020 SHALL advance every stage when enable is 1; a bubble (in_valid=0) propagates as a stage valid of 0.
REQ-021 SHALL accept one vector per cycle at full throughput when out_ready is held at 1.
REQ-022 SHALL hold out_min and out_idx stable while out_valid=1 and out_ready=0.
REQ-023 flush=1 SHALL clear every stage valid and out_valid on the next edge, regardless of stall; the input presented that cycle SHALL NOT be accepted (in_ready forced to 0 during flush).
REQ-024 flush SHALL take priority over enable when both act on the same edge.
REQ-025 Data and index registers SHALL NOT be required to clear on flush; only the valid registers matter.

Reset
REQ-026 While rst_n=0, all stage valids and out_valid SHALL be 0, out_min SHALL be 0 and out_idx SHALL be 0, asynchronously.
REQ-027 Deassertion of rst_n SHALL be synchronised to clk externally; the first possible accept SHALL be on the first rising edge with rst_n=1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight vectors, with no partial result emitted after release.

Structure
REQ-029 Package hmlf_pkg SHALL hold the constants HMLF_W=6, HMLF_N=8 and HMLF_IDXW=3, plus a typedef for the signed sample type and a typedef for the {value, index} pair.
REQ-030 A sub-module hmlf_min2_idx SHALL implement one combinational tree node: inputs are two {value, index} pairs, output is the winning pair, with ties resolved per REQ-016.
REQ-031 The tree, its registers and the enable/flush logic SHALL reside in hmlf_min8_pipe.

Verification
REQ-032 The bench SHALL cover: in_data = {7,6,5,4,3,2,1,0} as candidates 7..0 with out_ready=1 -> 3 cycles later out_min=0, out_idx=0, out_valid for exactly 1 cycle.
REQ-033 The bench SHALL cover: candidates (index 0..7) = 5,-32,31,-32,0,-1,-32,4 -> out_min=-32, out_idx=1 (tie, lowest index wins).
REQ-034 The bench SHALL cover: 10 back-to-back vectors with out_ready=1 -> 10 consecutive out_valid cycles with results in order, each matching a reference model.
REQ-035 The bench SHALL cover: out_ready=0 for 5 cycles while streaming -> in_ready falls once out_valid=1, the output holds stable, and after release there is no loss or duplication.
REQ-036 The bench SHALL cover: flush asserted with 3 vectors in flight -> out_valid=0 the next cycle and no stale result emitted afterwards.
REQ-037 The bench SHALL cover: rst_n pulsed low mid-stream -> outputs go to 0 immediately, and the first result after release comes from a post-reset vector with 3-cycle latency.
